fact_master: RTL and testbench
==============================

# fact_master

Bus master that runs one complete factorial job on the factorial core over the shared two-master bus. It sits directly upstream of the bus arbiter. It raises the request line and waits for the grant, then performs the register-access sequence on the core:

- write operand
- start
- poll done
- read result
- clear

It returns the 64-bit result to a local command port with a valid/ready handshake. Instantiated as master M0 or M1 at top level.

## Interface
- BASE_ADDR, 8'h00: bus address of the factorial core register block.
- BACKOFF, 4: idle cycles between polls when FACT_POLL_BACKOFF_EN is defined (range 1..15).
- clk  input  1  system clock, all logic on rising edge.
- reset_n  input  1  reset; synchronous, active-low.
- cmd_valid  input  1  host presents a job.
- cmd_ready  output  1  block can accept a job (high only in IDLE).
- cmd_operand  input  32  N for N!, captured on accept.
- result_valid  output  1  one-cycle pulse, result holds the answer.
- result  output  64  {result_h, result_l}; held until the next result_valid.
- M_req  output  1  bus request to arbiter.
- M_grant  input  1  bus grant from arbiter.
- M_wr  output  1  1 = write, 0 = read; qualified by M_grant.
- M_address  output  8  bus address.
- M_dout  output  32  write data.
- M_din  input  32  read data; same-cycle (combinational) response from the slave.

## Operation
- Core register offsets from BASE_ADDR:
  - +0 OPSTART
  - +1 OPCLEAR
  - +2 OPDONE (bit0)
  - +4 OPERAND
  - +5 RESULT_H
  - +6 RESULT_L
- FSM states: IDLE, REQ, WR_OP, WR_START, POLL, RD_H, RD_L, WR_CLR, DONE; plus WAIT when FACT_POLL_BACKOFF_EN is defined.
- **IDLE:**
  - cmd_ready=1.
  - On cmd_valid, latch cmd_operand and go to REQ.
- **REQ:**
  - M_req=1.
  - Wait for M_grant=1, then go to WR_OP.
- **WR_OP:** write latched operand to +4.
- **WR_START:** write 32'h1 to +0.
- **POLL:**
  - Read +2.
  - M_din[0]=1 → RD_H.
  - M_din[0]=0 → stay.
- **RD_H:** read +5 into result[63:32].
- **RD_L:** read +6 into result[31:0].
- **WR_CLR:** write 32'h1 to +1.
- **DONE:**
  - result_valid=1 for one cycle, M_req=0.
  - Next state IDLE.
- M_req is held at 1 continuously from REQ through WR_CLR.
- **Access cycles:** every bus access state performs its access only in a cycle with M_grant=1; otherwise it holds its state and the bus outputs are idle.
- **Idle bus outputs:** M_wr=0, M_address=0, M_dout=0. This applies whenever M_grant=0 or in IDLE/REQ/DONE.
- **Grant lost mid-job:** the job stalls without corruption and resumes at the same state when grant returns.
- cmd_valid outside IDLE is ignored; a new operand is never latched mid-job.
- Operand 0 is passed through unchanged; the core defines 0! = 1.

## Timing
- **Reset values:** state IDLE; all of the following are 0:
  - M_req, M_wr, M_address, M_dout
  - result_valid, result
  - operand latch
  - cmd_ready becomes 1 the first cycle after reset release.
- **reset_n=0 sampled at any edge:** return to IDLE next cycle and drop M_req. The core is not cleared; the next job's WR_OP/WR_START overwrite it.
- **Accept:** cmd_valid & cmd_ready at edge t → M_req=1 from t+1.
- **Arbiter latency:** the arbiter registers grant. With the other master idle and grant held elsewhere, M_grant rises at t+2.
- **Minimum job:** with grant immediate and done on the first poll, 6 granted cycles from WR_OP to WR_CLR, result_valid the cycle after WR_CLR.
- **Rearm:** cmd_ready returns 1 the cycle after result_valid.

## Configuration
- **FACT_POLL_BACKOFF_EN defined:**
  - After each POLL read with done=0, go to WAIT.
  - WAIT deasserts M_req for BACKOFF cycles, then returns to REQ.
  - After regaining grant, continue at POLL, not WR_OP.
  - This lets the other master use the bus during long computations.
- **Not defined:** no WAIT state; POLL reads every granted cycle and M_req is never dropped mid-job.

## Test plan
- **Basic job:** reset, then cmd_operand=5 with other master idle → bus writes +4=5 and +0=1, polls, reads H=0 and L=0x78, writes +1=1; result=64'h78 with a single result_valid pulse; M_req low after.
- **Wide result:** operand=20 with core done after 30 cycles → result=64'h21C3677C82B40000.
- **Contention:** other master holds the bus and requests continuously; job waits in REQ with no bus activity until the other master releases, then completes correctly.
- **Mid-job reset:** reset_n=0 for 1 cycle while in POLL → next cycle IDLE, M_req=0, cmd_ready=1, no result_valid; a following job with operand=3 returns 6.
- **Ignored command:** cmd_valid pulsed with operand=7 during a job for operand=4 → result=24, and the latched operand is unchanged.
- **Backoff (FACT_POLL_BACKOFF_EN, BACKOFF=4):** core done after 20 cycles → M_req drops for exactly 4 cycles after each not-done poll; final result correct.

Source files
------------

// File: rtl/fact_master_if.sv
// fact_master_if: shared two-master bus as seen by one master.
//   M_req      master -> arbiter  bus request
//   M_grant    arbiter -> master  bus grant (qualifies every access)
//   M_wr       master -> slave    1 = write, 0 = read
//   M_address  master -> slave    register address
//   M_dout     master -> slave    write data
//   M_din      slave  -> master   read data, same-cycle response
interface fact_master_if;
  logic        M_req;
  logic        M_grant;
  logic        M_wr;
  logic [7:0]  M_address;
  logic [31:0] M_dout;
  logic [31:0] M_din;

  modport master (
    output M_req, M_wr, M_address, M_dout,
    input  M_grant, M_din
  );

  modport slave (
    input  M_req, M_wr, M_address, M_dout,
    output M_grant, M_din
  );
endinterface

// File: rtl/fact_master.sv
// fact_master: runs one factorial job on the factorial core over the
// shared bus: write operand, start, poll done, read result (H then L),
// clear, then hand the 64-bit result back on the local command port.
//
// Parameters:
//   BASE_ADDR  bus address of the core register block
//   BACKOFF    idle cycles between polls (1..15), used only with the
//              optional macro below
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   cmd_valid/cmd_ready        job handshake, cmd_operand captured on accept
//   result_valid, result       one-cycle pulse, result held until next pulse
//   bus                        fact_master_if.master (M_req .. M_din)
// Optional feature:
//   FACT_POLL_BACKOFF_EN  when defined, a not-done poll releases the bus
//                         for BACKOFF cycles (WAIT state) before the next
//                         poll; the job resumes at POLL after regrant.
module fact_master #(
  parameter logic [7:0] BASE_ADDR = 8'h00,
  parameter int         BACKOFF   = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [31:0]          cmd_operand,
  output logic                 result_valid,
  output logic [63:0]          result,
  fact_master_if.master        bus
);

  localparam logic [7:0] OFS_START   = 8'd0;
  localparam logic [7:0] OFS_CLEAR   = 8'd1;
  localparam logic [7:0] OFS_DONE    = 8'd2;
  localparam logic [7:0] OFS_OPERAND = 8'd4;
  localparam logic [7:0] OFS_RES_H   = 8'd5;
  localparam logic [7:0] OFS_RES_L   = 8'd6;

  if (BACKOFF < 1 || BACKOFF > 15) begin : g_backoff_range
    $error("fact_master: BACKOFF must be in 1..15");
  end

  typedef enum logic [3:0] {
    IDLE, REQ, WR_OP, WR_START, POLL, RD_H, RD_L, WR_CLR, DONE
`ifdef FACT_POLL_BACKOFF_EN
    , WAIT
`endif
  } state_t;

  state_t      state;
  logic        req;
  logic [31:0] operand;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
`ifdef FACT_POLL_BACKOFF_EN
  logic [3:0]  wait_cnt;
  logic        resume_poll;  // set once the first poll has happened
`endif

  // Ready drops while reset is held so a job is never offered and lost.
  assign cmd_ready = (state == IDLE) && reset_n;
  assign bus.M_req = req;

  // Bus outputs are idle unless this cycle is a granted access cycle;
  // they follow M_grant combinationally so a lost grant never drives
  // a stale access.
  always_comb begin
    bus.M_wr      = 1'b0;
    bus.M_address = 8'h00;
    bus.M_dout    = 32'h0;
    if (bus.M_grant) begin
      case (state)
        WR_OP: begin
          bus.M_wr      = 1'b1;
          bus.M_address = BASE_ADDR + OFS_OPERAND;
          bus.M_dout    = operand;
        end
        WR_START: begin
          bus.M_wr      = 1'b1;
          bus.M_address = BASE_ADDR + OFS_START;
          bus.M_dout    = 32'h1;
        end
        POLL:    bus.M_address = BASE_ADDR + OFS_DONE;
        RD_H:    bus.M_address = BASE_ADDR + OFS_RES_H;
        RD_L:    bus.M_address = BASE_ADDR + OFS_RES_L;
        WR_CLR: begin
          bus.M_wr      = 1'b1;
          bus.M_address = BASE_ADDR + OFS_CLEAR;
          bus.M_dout    = 32'h1;
        end
        default: ;
      endcase
    end
  end

  // Result halves are plain data captures; the visible result register
  // only changes together with result_valid.
  always_ff @(posedge clk) begin
    if (bus.M_grant && state == RD_H) hi_q <= bus.M_din;
    if (bus.M_grant && state == RD_L) lo_q <= bus.M_din;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      req          <= 1'b0;
      result_valid <= 1'b0;
      result       <= 64'h0;
      operand      <= 32'h0;
`ifdef FACT_POLL_BACKOFF_EN
      wait_cnt     <= 4'h0;
      resume_poll  <= 1'b0;
`endif
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            operand <= cmd_operand;
            req     <= 1'b1;
            state   <= REQ;
`ifdef FACT_POLL_BACKOFF_EN
            resume_poll <= 1'b0;
`endif
          end
        end
        REQ: begin
          if (bus.M_grant) begin
`ifdef FACT_POLL_BACKOFF_EN
            state <= resume_poll ? POLL : WR_OP;
`else
            state <= WR_OP;
`endif
          end
        end
        WR_OP:    if (bus.M_grant) state <= WR_START;
        WR_START: if (bus.M_grant) state <= POLL;
        POLL: begin
          if (bus.M_grant) begin
            if (bus.M_din[0]) begin
              state <= RD_H;
            end else begin
`ifdef FACT_POLL_BACKOFF_EN
              state       <= WAIT;
              req         <= 1'b0;
              resume_poll <= 1'b1;
              wait_cnt    <= 4'(BACKOFF);
`else
              state <= POLL;
`endif
            end
          end
        end
        RD_H: if (bus.M_grant) state <= RD_L;
        RD_L: if (bus.M_grant) state <= WR_CLR;
        WR_CLR: begin
          if (bus.M_grant) begin
            result       <= {hi_q, lo_q};
            result_valid <= 1'b1;
            req          <= 1'b0;
            state        <= DONE;
          end
        end
        DONE: state <= IDLE;
`ifdef FACT_POLL_BACKOFF_EN
        // M_req stays low for exactly BACKOFF cycles spent in WAIT.
        WAIT: begin
          if (wait_cnt == 4'd1) begin
            req   <= 1'b1;
            state <= REQ;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_master.sv
module tb_fact_master;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tb_rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_operand;
  logic        result_valid;
  logic [63:0] result;

  fact_master_if bus ();

  fact_master #(.BASE_ADDR(8'h00), .BACKOFF(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_operand  (cmd_operand),
    .result_valid (result_valid),
    .result       (result),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int idle_viol = 0;

  // ---------------- arbiter model (registered grant) ----------------
  logic [1:0] owner;      // 0 none, 1 DUT, 2 other master
  logic       oth_req;
  logic       grant_block;
  int         core_delay;

  always_ff @(posedge clk) begin
    if (!tb_rst_n) owner <= 2'd0;
    else if (owner == 2'd1 && bus.M_req) owner <= 2'd1;
    else if (owner == 2'd2 && oth_req)   owner <= 2'd2;
    else if (bus.M_req)                  owner <= 2'd1;
    else if (oth_req)                    owner <= 2'd2;
    else                                 owner <= 2'd0;
  end
  assign bus.M_grant = (owner == 2'd1) && !grant_block;

  // ---------------- factorial core model ----------------
  function automatic logic [63:0] fact(input logic [31:0] n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 2; i <= 25 && i <= int'(n); i++) r = r * 64'(i);
    return r;
  endfunction

  logic [31:0] core_op;
  logic        core_busy;
  logic        core_done;
  int          core_cnt;
  logic [63:0] core_res;

  always_ff @(posedge clk) begin
    if (!tb_rst_n) begin
      core_op <= 32'h0; core_busy <= 1'b0; core_done <= 1'b0;
      core_cnt <= 0; core_res <= 64'h0;
    end else begin
      if (core_busy) begin
        if (core_cnt <= 1) begin
          core_done <= 1'b1; core_busy <= 1'b0; core_res <= fact(core_op);
        end else core_cnt <= core_cnt - 1;
      end
      if (bus.M_grant && bus.M_wr) begin
        case (bus.M_address)
          8'd4: core_op <= bus.M_dout;
          8'd0: begin
            if (core_delay == 0) begin
              core_done <= 1'b1; core_busy <= 1'b0; core_res <= fact(core_op);
            end else begin
              core_done <= 1'b0; core_busy <= 1'b1; core_cnt <= core_delay;
            end
          end
          8'd1: core_done <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.M_din = 32'h0;
    if (bus.M_grant && !bus.M_wr) begin
      case (bus.M_address)
        8'd2: bus.M_din = {31'h0, core_done};
        8'd5: bus.M_din = core_res[63:32];
        8'd6: bus.M_din = core_res[31:0];
        default: ;
      endcase
    end
  end

  // ---------------- bus log and scoreboard ----------------
  logic [40:0] log_q[$];     // {wr, address, data}
  logic [63:0] exp_q[$];

  always @(negedge clk) begin
    if (bus.M_grant && (bus.M_wr || bus.M_address != 8'h00))
      log_q.push_back({bus.M_wr, bus.M_address, bus.M_wr ? bus.M_dout : bus.M_din});
    if (!bus.M_grant && (bus.M_wr || bus.M_address != 8'h00 || bus.M_dout != 32'h0))
      idle_viol++;
  end

  always @(negedge clk) begin
    if (reset_n && result_valid) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_result_valid got=%h exp=no pulse", result);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        if (result !== e) begin
          bad++;
          $display("FAIL result got=%h exp=%h", result, e);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_cmd(input logic [31:0] op, input bit push, input logic [63:0] e);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL send_cmd_ready got=%b exp=1", cmd_ready);
    end
    if (push) exp_q.push_back(e);
    cmd_valid = 1'b1; cmd_operand = op;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_operand = 32'h0;
  endtask

  task automatic wait_rv(input int max, output bit got);
    got = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (result_valid) begin got = 1'b1; break; end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; tb_rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++; if (bus.M_req !== 1'b0) begin bad++; $display("FAIL rst_M_req got=%b exp=0", bus.M_req); end
    total++; if (bus.M_wr !== 1'b0) begin bad++; $display("FAIL rst_M_wr got=%b exp=0", bus.M_wr); end
    total++; if (bus.M_address !== 8'h0) begin bad++; $display("FAIL rst_M_address got=%h exp=0", bus.M_address); end
    total++; if (bus.M_dout !== 32'h0) begin bad++; $display("FAIL rst_M_dout got=%h exp=0", bus.M_dout); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL rst_result_valid got=%b exp=0", result_valid); end
    total++; if (result !== 64'h0) begin bad++; $display("FAIL rst_result got=%h exp=0", result); end
    @(posedge clk); #1;
    reset_n = 1'b1; tb_rst_n = 1'b1;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_basic();
    bit got;
    int n;
    log_q.delete();
    core_delay = 3;
    @(posedge clk); #1;
    send_cmd(32'd5, 1'b1, 64'h78);
    wait_rv(200, got);
    total++; if (!got) begin bad++; $display("FAIL basic_timeout got=no result_valid exp=pulse"); end
    n = log_q.size();
    total++; if (n < 6) begin bad++; $display("FAIL basic_log_len got=%0d exp>=6", n); end
    else begin
      total++; if (log_q[0] !== {1'b1, 8'd4, 32'd5}) begin bad++; $display("FAIL basic_wr_operand got=%h exp=%h", log_q[0], {1'b1, 8'd4, 32'd5}); end
      total++; if (log_q[1] !== {1'b1, 8'd0, 32'd1}) begin bad++; $display("FAIL basic_wr_start got=%h exp=%h", log_q[1], {1'b1, 8'd0, 32'd1}); end
      total++; if (log_q[n-3] !== {1'b0, 8'd5, 32'h0}) begin bad++; $display("FAIL basic_rd_h got=%h exp=%h", log_q[n-3], {1'b0, 8'd5, 32'h0}); end
      total++; if (log_q[n-2] !== {1'b0, 8'd6, 32'h78}) begin bad++; $display("FAIL basic_rd_l got=%h exp=%h", log_q[n-2], {1'b0, 8'd6, 32'h78}); end
      total++; if (log_q[n-1] !== {1'b1, 8'd1, 32'd1}) begin bad++; $display("FAIL basic_wr_clr got=%h exp=%h", log_q[n-1], {1'b1, 8'd1, 32'd1}); end
    end
    @(negedge clk);
    total++; if (bus.M_req !== 1'b0) begin bad++; $display("FAIL basic_req_after got=%b exp=0", bus.M_req); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL basic_rearm got=%b exp=1", cmd_ready); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL basic_single_pulse got=%b exp=0", result_valid); end
  endtask

  task automatic test_min_job();
    bit got;
    log_q.delete();
    core_delay = 0;
    send_cmd(32'd0, 1'b1, 64'h1);
    wait_rv(100, got);
    total++; if (!got) begin bad++; $display("FAIL min_timeout got=no result_valid exp=pulse"); end
    total++; if (log_q.size() != 6) begin bad++; $display("FAIL min_granted_cycles got=%0d exp=6", log_q.size()); end
    else begin
      total++; if (log_q[0] !== {1'b1, 8'd4, 32'd0}) begin bad++; $display("FAIL min_wr_operand got=%h exp=%h", log_q[0], {1'b1, 8'd4, 32'd0}); end
    end
    @(negedge clk);
  endtask

  task automatic test_wide();
    bit got;
    core_delay = 30;
    send_cmd(32'd20, 1'b1, 64'h21C3677C82B40000);
    wait_rv(300, got);
    total++; if (!got) begin bad++; $display("FAIL wide_timeout got=no result_valid exp=pulse"); end
    @(negedge clk);
  endtask

  task automatic test_contention();
    bit got;
    oth_req = 1'b1;
    repeat (3) @(posedge clk); #1;
    log_q.delete();
    core_delay = 5;
    send_cmd(32'd6, 1'b1, 64'h2D0);
    repeat (20) @(negedge clk);
    total++; if (log_q.size() != 0) begin bad++; $display("FAIL cont_bus_activity got=%0d exp=0", log_q.size()); end
    total++; if (bus.M_req !== 1'b1) begin bad++; $display("FAIL cont_req_held got=%b exp=1", bus.M_req); end
    total++; if (bus.M_grant !== 1'b0) begin bad++; $display("FAIL cont_grant got=%b exp=0", bus.M_grant); end
    @(posedge clk); #1;
    oth_req = 1'b0;
    wait_rv(200, got);
    total++; if (!got) begin bad++; $display("FAIL cont_timeout got=no result_valid exp=pulse"); end
    total++; if (log_q.size() == 0 || log_q[0] !== {1'b1, 8'd4, 32'd6}) begin
      bad++; $display("FAIL cont_wr_operand got=%h exp=%h", log_q.size() ? log_q[0] : 41'h0, {1'b1, 8'd4, 32'd6});
    end
    @(negedge clk);
  endtask

  task automatic test_grant_loss();
    bit got;
    int n0;
    int k;
    log_q.delete();
    core_delay = 4;
    send_cmd(32'd10, 1'b1, 64'h375F00);
    k = 0;
    while (log_q.size() < 1 && k < 100) begin @(negedge clk); k++; end
    total++; if (k >= 100) begin bad++; $display("FAIL loss_no_wr_op got=%0d exp>=1", log_q.size()); end
    @(posedge clk); #1;
    grant_block = 1'b1;
    n0 = log_q.size();
    repeat (6) @(negedge clk);
    total++; if (log_q.size() != n0) begin bad++; $display("FAIL loss_stall got=%0d exp=%0d", log_q.size(), n0); end
    @(posedge clk); #1;
    grant_block = 1'b0;
    wait_rv(200, got);
    total++; if (!got) begin bad++; $display("FAIL loss_timeout got=no result_valid exp=pulse"); end
    total++; if (log_q.size() < 2 || log_q[1] !== {1'b1, 8'd0, 32'd1}) begin
      bad++; $display("FAIL loss_wr_start got=%h exp=%h", log_q.size() > 1 ? log_q[1] : 41'h0, {1'b1, 8'd0, 32'd1});
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    bit got;
    int k;
    log_q.delete();
    core_delay = 50;
    send_cmd(32'd9, 1'b0, 64'h0);
    k = 0;
    while (log_q.size() < 3 && k < 100) begin @(negedge clk); k++; end
    total++; if (k >= 100) begin bad++; $display("FAIL mreset_no_poll got=%0d exp>=3", log_q.size()); end
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    total++; if (bus.M_req !== 1'b0) begin bad++; $display("FAIL mreset_req got=%b exp=0", bus.M_req); end
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL mreset_ready got=%b exp=1", cmd_ready); end
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL mreset_rv got=%b exp=0", result_valid); end
    repeat (10) @(negedge clk);
    core_delay = 2;
    send_cmd(32'd3, 1'b1, 64'h6);
    wait_rv(200, got);
    total++; if (!got) begin bad++; $display("FAIL mreset_next_timeout got=no result_valid exp=pulse"); end
    @(negedge clk);
  endtask

  task automatic test_ignored_cmd();
    bit got;
    log_q.delete();
    core_delay = 15;
    send_cmd(32'd4, 1'b1, 64'h18);
    repeat (2) @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_operand = 32'd7;
    repeat (5) @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_operand = 32'd0;
    wait_rv(200, got);
    total++; if (!got) begin bad++; $display("FAIL ign_timeout got=no result_valid exp=pulse"); end
    total++; if (log_q.size() == 0 || log_q[0] !== {1'b1, 8'd4, 32'd4}) begin
      bad++; $display("FAIL ign_operand got=%h exp=%h", log_q.size() ? log_q[0] : 41'h0, {1'b1, 8'd4, 32'd4});
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit got;
    core_delay = 1;
    send_cmd(32'd1, 1'b1, 64'h1);
    wait_rv(100, got);
    total++; if (!got) begin bad++; $display("FAIL b2b_first got=no result_valid exp=pulse"); end
    @(posedge clk); #1;
    send_cmd(32'd12, 1'b1, 64'h1C8CFC00);
    wait_rv(100, got);
    total++; if (!got) begin bad++; $display("FAIL b2b_second got=no result_valid exp=pulse"); end
    @(negedge clk);
  endtask

`ifdef FACT_POLL_BACKOFF_EN
  task automatic test_backoff();
    int run, runs, badruns, polls;
    bit started;
    run = 0; runs = 0; badruns = 0; polls = 0; started = 1'b0;
    log_q.delete();
    core_delay = 20;
    send_cmd(32'd5, 1'b1, 64'h78);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (result_valid) break;
      if (bus.M_req) begin
        started = 1'b1;
        if (run > 0) begin
          runs++;
          if (run != 4) badruns++;
          run = 0;
        end
      end else if (started) run++;
    end
    foreach (log_q[i]) if (log_q[i] === {1'b0, 8'd2, 32'd0}) polls++;
    total++; if (badruns != 0) begin bad++; $display("FAIL backoff_len got=%0d bad runs exp=0", badruns); end
    total++; if (runs != polls || runs == 0) begin bad++; $display("FAIL backoff_count got=%0d exp=%0d", runs, polls); end
    @(negedge clk);
  endtask
`endif

  task automatic test_final();
    total++; if (idle_viol != 0) begin bad++; $display("FAIL idle_outputs got=%0d exp=0", idle_viol); end
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL pending_results got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    cmd_valid = 1'b0; cmd_operand = 32'h0;
    oth_req = 1'b0; grant_block = 1'b0; core_delay = 0;
    test_reset();
    test_basic();
    test_min_job();
    test_wide();
    test_contention();
    test_grant_loss();
    test_mid_reset();
    test_ignored_cmd();
    test_back_to_back();
`ifdef FACT_POLL_BACKOFF_EN
    test_backoff();
`endif
    repeat (3) @(negedge clk);
    test_final();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
